ifu_pfq: RTL and testbench
==========================

# ifu_pfq

Parametrised instruction fetch unit with an in-order prefetch queue, multiple outstanding BIU fetches and redirect flush. It sits between the BIU, which returns instructions in request order, and the EXU. It issues sequential fetch addresses up to a credit limit, buffers returned instructions with their PCs, and delivers them to the EXU over a valid/ready handshake. On a taken-branch redirect it discards all queued and in-flight fetches and restarts at the new target.

## Interface
- AW, 32: address width.
- DW, 32: instruction width.
- DEPTH, 4: queue entries and maximum in-flight fetches; power of two, 2..16.
- RST_PC, 0: first fetch address after reset; bits [1:0] must be 0.

- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- ifu2biu_req_vld  out  1  fetch request valid.
- ifu2biu_req_rdy  in  1  BIU accepts request.
- ifu2biu_req_pc  out  AW  fetch address.
- biu2ifu_rsp_vld  in  1  fetch data valid; responses are in request order.
- biu2ifu_rsp_rdy  out  1  always 1 out of reset; 0 while rst is high.
- biu2ifu_rsp_inst  in  DW  fetched instruction.
- ifu2exu_req_vld  out  1  head entry valid.
- ifu2exu_req_rdy  in  1  EXU accepts head.
- ifu2exu_req_ir  out  DW  head instruction.
- ifu2exu_req_pc  out  AW  head PC.
- exu2ifu_redir_vld  in  1  redirect, single-cycle pulse.
- exu2ifu_redir_pc  in  AW  redirect target; bits [1:0] are ignored and treated as 0.

## Operation
**State**
- fpc: next fetch address.
- rpc: PC of the next non-dropped response.
- ost: in-flight fetch count, 0..DEPTH.
- drop: responses still to be discarded, 0..DEPTH.
- cnt: queue occupancy, 0..DEPTH.
- Circular queue of {pc, inst} with head and tail pointers that wrap modulo DEPTH.

**Reset** (while rst is high and on the first cycle after it)
- fpc = rpc = RST_PC; ost = drop = cnt = 0; pointers = 0.
- All outputs are 0: both valids, ir, pc and biu2ifu_rsp_rdy.

**Fetch**
- ifu2biu_req_vld = (ost + cnt < DEPTH) & ~exu2ifu_redir_vld.
- ifu2biu_req_pc = fpc.
- On a request handshake: fpc += 4 (wraps modulo 2^AW) and ost increments.

**Response**
- biu2ifu_rsp_rdy = 1, because the credit rule guarantees queue space.
- Every response handshake decrements ost.
- If drop > 0: the data is discarded and drop decrements.
- Otherwise: {rpc, inst} is pushed at the tail and rpc += 4.

**Delivery**
- ifu2exu_req_vld = (cnt > 0) & ~exu2ifu_redir_vld.
- ir and pc show the head entry.
- A delivery handshake pops the head.
- When the queue is empty, ir and pc hold the last-popped values (0 after reset).

**Redirect** (pulse in cycle N)
- In cycle N, request and delivery valids are forced to 0.
- At the end of cycle N:
  - queue flushed: cnt = 0, head = tail;
  - fpc = rpc = {redir_pc[AW-1:2], 2'b00};
  - ost = ost − rsp_hs;
  - drop = ost − rsp_hs.
- A response arriving in cycle N is discarded regardless of drop.
- Fetch restarts in cycle N+1.

**Simultaneous events**
- Push and pop in the same cycle leave cnt unchanged.
- Request and response in the same cycle leave ost unchanged.
- A push into a full queue cannot occur by construction.

## Timing
- Request handshake in cycle N: the BIU responds in cycle N+k with k ≥ 1; the entry is pushed at the end of N+k; ifu2exu_req_vld is first high in N+k+1.
- Back-to-back throughput: one instruction per cycle when the BIU is fully pipelined and the EXU is always ready.
- Redirect pulse in cycle N: ifu2biu_req_vld can be high with the target PC in N+1; the first target instruction reaches the EXU no earlier than N+3.
- Credit stall: ifu2biu_req_vld drops combinationally in the same cycle ost + cnt reaches DEPTH.

## Configuration
- IFU_PFQ_BYPASS_EN defined:
  - When cnt == 0, drop == 0, no redirect, and a response handshake occurs, ifu2exu_req_vld is driven combinationally from the response, with ir = rsp_inst and pc = rpc.
  - If the EXU accepts in the same cycle, the entry is not pushed; rpc still increments.
  - Load-to-use latency drops by 1 cycle (N+k instead of N+k+1).
- Undefined: responses always pass through the queue; there is no combinational path from biu2ifu_* to ifu2exu_*.

## Test plan
- **Reset:** RST_PC=0x100; BIU and EXU always ready, 1-cycle BIU latency. Expect fetches at 0x100, 0x104, 0x108…; EXU receives pc 0x100, 0x104… in order, one per cycle after fill.
- **Credit:** DEPTH=4, EXU rdy=0, BIU responds with 1-cycle latency. Expect exactly 4 request handshakes, then ifu2biu_req_vld=0 and cnt=4. Raise rdy for one cycle: expect exactly one more request.
- **Redirect with in-flight fetches:** redirect to 0x2003 while ost=3 and cnt=2. Expect the queue emptied, the next 3 responses discarded, the next fetch at 0x2000, and the first EXU pc 0x2000.
- **Same-cycle redirect and response:** redirect while a response handshakes and ost=1. Expect that response dropped, drop=0 afterwards, and no stale instruction delivered.
- **Wrap:** RST_PC = 2^AW − 8, unbounded run. Expect fetch pc to wrap 0xFFFFFFFC → 0x00000000, and the queue pointers to wrap through ≥3·DEPTH pushes with data order intact.
- **Bypass:** with IFU_PFQ_BYPASS_EN, empty queue, EXU ready. Expect a response in cycle M to be seen by the EXU in M, with cnt staying 0. Without the macro, expect it in M+1.

Source files
------------

// File: rtl/ifu_pfq.sv
// Instruction fetch prefetch queue: credit-limited sequential fetch, in-order buffering, redirect flush.
// Optional IFU_PFQ_BYPASS_EN forwards a response straight to the EXU when the queue is empty.
module ifu_pfq #(
  parameter int unsigned    AW     = 32,
  parameter int unsigned    DW     = 32,
  parameter int unsigned    DEPTH  = 4,
  parameter logic [AW-1:0]  RST_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          ifu2biu_req_vld,
  input  logic          ifu2biu_req_rdy,
  output logic [AW-1:0] ifu2biu_req_pc,
  input  logic          biu2ifu_rsp_vld,
  output logic          biu2ifu_rsp_rdy,
  input  logic [DW-1:0] biu2ifu_rsp_inst,
  output logic          ifu2exu_req_vld,
  input  logic          ifu2exu_req_rdy,
  output logic [DW-1:0] ifu2exu_req_ir,
  output logic [AW-1:0] ifu2exu_req_pc,
  input  logic          exu2ifu_redir_vld,
  input  logic [AW-1:0] exu2ifu_redir_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;

  logic [AW-1:0] fpc;
  logic [AW-1:0] rpc;
  logic [CW-1:0] ost;
  logic [CW-1:0] drop;
  logic [CW-1:0] cnt;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [DW-1:0] last_ir;
  logic [AW-1:0] last_pc;
  logic          live;

  logic [DW-1:0] mem_ir [DEPTH];
  logic [AW-1:0] mem_pc [DEPTH];

  logic          live_c;
  logic          empty;
  logic          credit;
  logic          req_hs;
  logic          rsp_hs;
  logic          byp;
  logic          pop;
  logic          pop_q;
  logic          push;
  logic [AW-1:0] redir_tgt;
  logic          unused_redir_lsb;

  assign redir_tgt        = {exu2ifu_redir_pc[AW-1:2], 2'b00};
  assign unused_redir_lsb = ^exu2ifu_redir_pc[1:0];

  // Outputs stay quiet during reset and the first cycle after it.
  assign live_c = live & ~rst;
  assign empty  = (cnt == '0);
  assign credit = (SW'(ost) + SW'(cnt)) < SW'(DEPTH);

  always_comb begin
    byp             = 1'b0;
    biu2ifu_rsp_rdy = live_c;
    rsp_hs          = live_c & biu2ifu_rsp_vld;
    ifu2biu_req_vld = live_c & credit & ~exu2ifu_redir_vld;
    ifu2biu_req_pc  = live_c ? fpc : '0;
    req_hs          = ifu2biu_req_vld & ifu2biu_req_rdy;
`ifdef IFU_PFQ_BYPASS_EN
    byp = live_c & empty & (drop == '0) & ~exu2ifu_redir_vld & rsp_hs;
`endif
    ifu2exu_req_vld = live_c & ~exu2ifu_redir_vld & (~empty | byp);
    ifu2exu_req_ir  = last_ir;
    ifu2exu_req_pc  = last_pc;
    if (!empty) begin
      ifu2exu_req_ir = mem_ir[head];
      ifu2exu_req_pc = mem_pc[head];
    end
`ifdef IFU_PFQ_BYPASS_EN
    if (byp) begin
      ifu2exu_req_ir = biu2ifu_rsp_inst;
      ifu2exu_req_pc = rpc;
    end
`endif
    if (!live_c) begin
      ifu2exu_req_ir = '0;
      ifu2exu_req_pc = '0;
    end
    pop   = ifu2exu_req_vld & ifu2exu_req_rdy;
    pop_q = pop & ~empty;
    // A bypassed instruction the EXU takes right away never enters the queue.
    push  = rsp_hs & ~exu2ifu_redir_vld & (drop == '0) & ~(byp & pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc     <= RST_PC;
      rpc     <= RST_PC;
      ost     <= '0;
      drop    <= '0;
      cnt     <= '0;
      head    <= '0;
      tail    <= '0;
      last_ir <= '0;
      last_pc <= '0;
      live    <= 1'b0;
    end else begin
      live <= 1'b1;
      if (exu2ifu_redir_vld) begin
        // Everything still in flight belongs to the old stream and must be dropped.
        fpc  <= redir_tgt;
        rpc  <= redir_tgt;
        ost  <= ost - CW'(rsp_hs);
        drop <= ost - CW'(rsp_hs);
        cnt  <= '0;
        head <= tail;
      end else begin
        if (req_hs) fpc <= fpc + AW'(4);
        ost <= ost + CW'(req_hs) - CW'(rsp_hs);
        if (rsp_hs) begin
          if (drop != '0) drop <= drop - CW'(1);
          else            rpc  <= rpc + AW'(4);
        end
        if (push)  tail <= tail + PW'(1);
        if (pop_q) head <= head + PW'(1);
        cnt <= cnt + CW'(push) - CW'(pop_q);
        if (pop) begin
          last_ir <= ifu2exu_req_ir;
          last_pc <= ifu2exu_req_pc;
        end
      end
    end
  end

  // Queue storage; needs no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_ir[tail] <= biu2ifu_rsp_inst;
      mem_pc[tail] <= rpc;
    end
  end

endmodule

// File: tb/tb_ifu_pfq.sv
// Randomized bench for ifu_pfq: cycle-level queue model plus scenario checks.
module tb_ifu_pfq;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] RSTPC = 32'h0000_0100;
`ifdef IFU_PFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct { logic [31:0] pc; logic [31:0] ir; } ent_t;
  typedef struct { logic [31:0] pc; logic [31:0] ir; int due; } pend_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ifu2biu_req_vld;
  logic          ifu2biu_req_rdy = 1'b0;
  logic [AW-1:0] ifu2biu_req_pc;
  logic          biu2ifu_rsp_vld = 1'b0;
  logic          biu2ifu_rsp_rdy;
  logic [DW-1:0] biu2ifu_rsp_inst = '0;
  logic          ifu2exu_req_vld;
  logic          ifu2exu_req_rdy = 1'b0;
  logic [DW-1:0] ifu2exu_req_ir;
  logic [AW-1:0] ifu2exu_req_pc;
  logic          exu2ifu_redir_vld = 1'b0;
  logic [AW-1:0] exu2ifu_redir_pc = '0;

  ifu_pfq #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .RST_PC(RSTPC)) dut (
    .clk(clk), .rst(rst),
    .ifu2biu_req_vld(ifu2biu_req_vld), .ifu2biu_req_rdy(ifu2biu_req_rdy),
    .ifu2biu_req_pc(ifu2biu_req_pc),
    .biu2ifu_rsp_vld(biu2ifu_rsp_vld), .biu2ifu_rsp_rdy(biu2ifu_rsp_rdy),
    .biu2ifu_rsp_inst(biu2ifu_rsp_inst),
    .ifu2exu_req_vld(ifu2exu_req_vld), .ifu2exu_req_rdy(ifu2exu_req_rdy),
    .ifu2exu_req_ir(ifu2exu_req_ir), .ifu2exu_req_pc(ifu2exu_req_pc),
    .exu2ifu_redir_vld(exu2ifu_redir_vld), .exu2ifu_redir_pc(exu2ifu_redir_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat_lo = 1;
  int lat_hi = 1;

  // Reference model state
  logic [31:0] m_fpc = RSTPC;
  logic [31:0] m_rpc = RSTPC;
  int          m_ost = 0;
  int          m_drop = 0;
  bit          m_live = 1'b0;
  logic [31:0] m_last_ir = '0;
  logic [31:0] m_last_pc = '0;
  ent_t        m_q[$];
  pend_t       pend[$];

  // DUT observations from the most recent tick
  bit          d_req_hs, d_rsp_hs, d_exu_hs, d_req_vld, d_exu_vld;
  logic [31:0] d_req_pc, d_exu_pc;

  task automatic tick();
    bit e_live, e_req_vld, e_exu_vld, byp, rsp_hs, req_hs, pop;
    logic [31:0] e_ir, e_pc, e_req_pc;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      biu2ifu_rsp_vld  = 1'b1;
      biu2ifu_rsp_inst = pend[0].ir;
    end else begin
      biu2ifu_rsp_vld  = 1'b0;
      biu2ifu_rsp_inst = $urandom;
    end
    @(negedge clk);
    e_live    = m_live && !rst;
    rsp_hs    = e_live && biu2ifu_rsp_vld;
    e_req_vld = e_live && (m_ost + m_q.size() < DEPTH) && !exu2ifu_redir_vld;
    e_req_pc  = e_live ? m_fpc : 32'h0;
    byp       = BYP && e_live && m_q.size() == 0 && m_drop == 0 && !exu2ifu_redir_vld && rsp_hs;
    e_exu_vld = e_live && !exu2ifu_redir_vld && (m_q.size() > 0 || byp);
    if (!e_live)              begin e_ir = '0;               e_pc = '0;        end
    else if (m_q.size() > 0)  begin e_ir = m_q[0].ir;        e_pc = m_q[0].pc; end
    else if (byp)             begin e_ir = biu2ifu_rsp_inst; e_pc = m_rpc;     end
    else                      begin e_ir = m_last_ir;        e_pc = m_last_pc; end

    checks++;
    if (ifu2biu_req_vld !== e_req_vld) begin
      errors++; $display("FAIL req_vld cyc=%0d got %b expected %b", cyc, ifu2biu_req_vld, e_req_vld);
    end
    checks++;
    if (ifu2biu_req_pc !== e_req_pc) begin
      errors++; $display("FAIL req_pc cyc=%0d got %h expected %h", cyc, ifu2biu_req_pc, e_req_pc);
    end
    checks++;
    if (biu2ifu_rsp_rdy !== e_live) begin
      errors++; $display("FAIL rsp_rdy cyc=%0d got %b expected %b", cyc, biu2ifu_rsp_rdy, e_live);
    end
    checks++;
    if (ifu2exu_req_vld !== e_exu_vld) begin
      errors++; $display("FAIL exu_vld cyc=%0d got %b expected %b", cyc, ifu2exu_req_vld, e_exu_vld);
    end
    checks++;
    if (ifu2exu_req_ir !== e_ir) begin
      errors++; $display("FAIL exu_ir cyc=%0d got %h expected %h", cyc, ifu2exu_req_ir, e_ir);
    end
    checks++;
    if (ifu2exu_req_pc !== e_pc) begin
      errors++; $display("FAIL exu_pc cyc=%0d got %h expected %h", cyc, ifu2exu_req_pc, e_pc);
    end

    d_req_vld = ifu2biu_req_vld;
    d_exu_vld = ifu2exu_req_vld;
    d_req_pc  = ifu2biu_req_pc;
    d_exu_pc  = ifu2exu_req_pc;
    d_req_hs  = ifu2biu_req_vld && ifu2biu_req_rdy;
    d_rsp_hs  = biu2ifu_rsp_vld && biu2ifu_rsp_rdy;
    d_exu_hs  = ifu2exu_req_vld && ifu2exu_req_rdy;
    req_hs    = e_req_vld && ifu2biu_req_rdy;
    pop       = e_exu_vld && ifu2exu_req_rdy;

    @(posedge clk);
    if (rst) begin
      m_fpc = RSTPC; m_rpc = RSTPC; m_ost = 0; m_drop = 0; m_live = 1'b0;
      m_last_ir = '0; m_last_pc = '0; m_q.delete(); pend.delete();
    end else begin
      m_live = 1'b1;
      if (rsp_hs) void'(pend.pop_front());
      if (exu2ifu_redir_vld) begin
        m_q.delete();
        m_fpc  = {exu2ifu_redir_pc[31:2], 2'b00};
        m_rpc  = m_fpc;
        m_ost  = m_ost - int'(rsp_hs);
        m_drop = m_ost;
      end else begin
        if (pop) begin
          m_last_ir = e_ir; m_last_pc = e_pc;
          if (m_q.size() > 0) void'(m_q.pop_front());
        end
        if (rsp_hs) begin
          if (m_drop > 0) m_drop--;
          else begin
            if (!(byp && pop)) m_q.push_back('{pc: m_rpc, ir: biu2ifu_rsp_inst});
            m_rpc = m_rpc + 32'd4;
          end
        end
        if (req_hs) begin
          pend.push_back('{pc: m_fpc, ir: $urandom, due: cyc + int'($urandom_range(lat_hi, lat_lo))});
          m_fpc = m_fpc + 32'd4;
        end
        m_ost = m_ost + int'(req_hs) - int'(rsp_hs);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; exu2ifu_redir_vld = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    ifu2biu_req_rdy = 1'b1; ifu2exu_req_rdy = 1'b1; lat_lo = 1; lat_hi = 1;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if (d_req_vld !== 1'b0 || d_exu_vld !== 1'b0) begin
      errors++; $display("FAIL reset_quiet got req %b exu %b required 0 0", d_req_vld, d_exu_vld);
    end
    tick();
    checks++;
    if (d_req_hs !== 1'b1 || d_req_pc !== RSTPC) begin
      errors++; $display("FAIL reset_first_fetch got hs %b pc %h required 1 %h", d_req_hs, d_req_pc, RSTPC);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc = RSTPC;
    logic [31:0] exp_fpc = RSTPC + 32'd4;
    int tail_del = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (d_exu_hs) begin
        checks++;
        if (d_exu_pc !== exp_pc) begin
          errors++; $display("FAIL stream_pc got %h required %h", d_exu_pc, exp_pc);
        end
        exp_pc = exp_pc + 32'd4;
        if (i >= 15) tail_del++;
      end
      if (d_req_hs) begin
        checks++;
        if (d_req_pc !== exp_fpc) begin
          errors++; $display("FAIL stream_fetch got %h required %h", d_req_pc, exp_fpc);
        end
        exp_fpc = exp_fpc + 32'd4;
      end
    end
    checks++;
    if (tail_del !== 15) begin
      errors++; $display("FAIL stream_throughput got %0d deliveries required 15", tail_del);
    end
  endtask

  task automatic test_credit();
    int n = 0;
    do_reset();
    ifu2exu_req_rdy = 1'b0; ifu2biu_req_rdy = 1'b1; lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 14; i++) begin tick(); n += int'(d_req_hs); end
    checks++;
    if (n !== DEPTH || d_req_vld !== 1'b0 || d_exu_vld !== 1'b1) begin
      errors++; $display("FAIL credit_fill got %0d reqs vld %b required %0d vld 0", n, d_req_vld, DEPTH);
    end
    ifu2exu_req_rdy = 1'b1; tick(); ifu2exu_req_rdy = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin tick(); n += int'(d_req_hs); end
    checks++;
    if (n !== 1) begin
      errors++; $display("FAIL credit_one_more got %0d reqs required 1", n);
    end
  endtask

  task automatic test_redirect();
    bit got_req = 1'b0;
    logic [31:0] exp_pc = 32'h2000;
    int n = 0;
    do_reset();
    ifu2exu_req_rdy = 1'b0; ifu2biu_req_rdy = 1'b1; lat_lo = 1; lat_hi = 1;
    tick(); tick();
    lat_lo = 40; lat_hi = 40;
    tick(); tick(); tick();
    ifu2biu_req_rdy = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (d_exu_vld !== 1'b1 || d_exu_pc !== RSTPC) begin
      errors++; $display("FAIL redir_setup got vld %b pc %h required 1 %h", d_exu_vld, d_exu_pc, RSTPC);
    end
    exu2ifu_redir_vld = 1'b1; exu2ifu_redir_pc = 32'h2003;
    ifu2biu_req_rdy = 1'b1; ifu2exu_req_rdy = 1'b1; lat_lo = 1; lat_hi = 1;
    tick();
    exu2ifu_redir_vld = 1'b0;
    checks++;
    if (d_req_vld !== 1'b0 || d_exu_vld !== 1'b0) begin
      errors++; $display("FAIL redir_mask got req %b exu %b required 0 0", d_req_vld, d_exu_vld);
    end
    for (int i = 0; i < 80; i++) begin
      tick();
      if (d_req_hs && !got_req) begin
        got_req = 1'b1;
        checks++;
        if (d_req_pc !== 32'h2000) begin
          errors++; $display("FAIL redir_fetch got %h required 00002000", d_req_pc);
        end
      end
      if (d_exu_hs) begin
        checks++;
        if (d_exu_pc !== exp_pc) begin
          errors++; $display("FAIL redir_exu_pc got %h required %h", d_exu_pc, exp_pc);
        end
        exp_pc = exp_pc + 32'd4; n++;
      end
    end
    checks++;
    if (n < 4) begin
      errors++; $display("FAIL redir_timeout got %0d deliveries required >=4", n);
    end
  endtask

  task automatic test_same_cycle();
    bit seen = 1'b0;
    do_reset();
    ifu2exu_req_rdy = 1'b1; ifu2biu_req_rdy = 1'b1; lat_lo = 3; lat_hi = 3;
    tick();
    ifu2biu_req_rdy = 1'b0;
    tick(); tick();
    exu2ifu_redir_vld = 1'b1; exu2ifu_redir_pc = 32'h3000;
    tick();
    exu2ifu_redir_vld = 1'b0;
    checks++;
    if (d_rsp_hs !== 1'b1 || d_exu_vld !== 1'b0) begin
      errors++; $display("FAIL same_cycle_rsp got rsp_hs %b exu %b required 1 0", d_rsp_hs, d_exu_vld);
    end
    ifu2biu_req_rdy = 1'b1; lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (d_exu_hs) begin
        seen = 1'b1;
        checks++;
        if (d_exu_pc !== 32'h3000) begin
          errors++; $display("FAIL same_cycle_first got %h required 00003000", d_exu_pc);
        end
      end
    end
    if (!seen) begin
      checks++; errors++; $display("FAIL same_cycle_timeout got none required delivery");
    end
  endtask

  task automatic test_bypass();
    int m = -1, d = -1;
    do_reset();
    ifu2exu_req_rdy = 1'b1; ifu2biu_req_rdy = 1'b1; lat_lo = 2; lat_hi = 2;
    tick();
    ifu2biu_req_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (d_rsp_hs && m < 0) m = cyc;
      if (d_exu_hs && d < 0) d = cyc;
    end
    checks++;
    if (m < 0 || d < 0 || d - m !== (BYP ? 0 : 1)) begin
      errors++; $display("FAIL bypass_latency got rsp %0d exu %0d required delta %0d", m, d, BYP ? 0 : 1);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc = 32'hFFFF_FFF8;
    logic [31:0] prev = '0;
    bit wrapped = 1'b0;
    int n = 0;
    exu2ifu_redir_vld = 1'b1; exu2ifu_redir_pc = 32'hFFFF_FFF8;
    lat_lo = 1; lat_hi = 4;
    tick();
    exu2ifu_redir_vld = 1'b0;
    for (int i = 0; i < 250; i++) begin
      ifu2biu_req_rdy = ($urandom_range(3, 0) != 0);
      ifu2exu_req_rdy = ($urandom_range(3, 0) != 0);
      tick();
      if (d_req_hs) begin
        if (prev == 32'hFFFF_FFFC) begin
          wrapped = 1'b1;
          checks++;
          if (d_req_pc !== 32'h0) begin
            errors++; $display("FAIL wrap_fetch got %h required 00000000", d_req_pc);
          end
        end
        prev = d_req_pc;
      end
      if (d_exu_hs) begin
        checks++;
        if (d_exu_pc !== exp_pc) begin
          errors++; $display("FAIL wrap_order got %h required %h", d_exu_pc, exp_pc);
        end
        exp_pc = exp_pc + 32'd4; n++;
      end
    end
    checks++;
    if (!wrapped || n < 3 * DEPTH) begin
      errors++; $display("FAIL wrap_coverage got wrapped %b deliveries %0d required 1 >=%0d", wrapped, n, 3 * DEPTH);
    end
  endtask

  task automatic test_random();
    lat_lo = 1; lat_hi = 5;
    for (int i = 0; i < 400; i++) begin
      ifu2biu_req_rdy   = ($urandom_range(2, 0) != 0);
      ifu2exu_req_rdy   = ($urandom_range(2, 0) != 0);
      exu2ifu_redir_vld = ($urandom_range(24, 0) == 0);
      exu2ifu_redir_pc  = $urandom;
      tick();
    end
    exu2ifu_redir_vld = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_credit();
    test_redirect();
    test_same_cycle();
    test_bypass();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
